rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
// - Round-robin arbiter that shares the 4:1 word mux datapath (combinational_logic task2 path) between NUM_REQ requesters.
// - Each requester offers one DATA_W word per valid/ready beat. The arbiter picks a winner, drives the mux select, and registers the chosen word into a single-entry output stage with valid/ready.
// - Optional lock lets one requester keep the grant for a multi-beat burst, capped at LOCK_MAX beats.
// - Sits between requester logic and any downstream consumer of the shared word path.
// PARAMETERS
// - NUM_REQ   4   number of requesters; power of 2, >= 2
// - DATA_W    32  word width
// - LOCK_MAX  8   max consecutive beats one owner may hold a lock; >= 1
// - SEL_W     $clog2(NUM_REQ)  derived localparam, not overridable
// PORTS
// - clk        in   1               rising-edge clock
// - rst        in   1               synchronous, active-high reset
// - req_valid  in   NUM_REQ         requester i offers a word
// - req_data   in   NUM_REQ*DATA_W  packed words; requester i at [i*DATA_W +: DATA_W]
// - req_lock   in   NUM_REQ         with the beat: keep grant for the next beat
// - req_ready  out  NUM_REQ         one-hot or zero; beat i accepted when req_valid[i] && req_ready[i]
// - grant_sel  out  SEL_W           current mux select, combinational; valid only when |req_ready
// - out_valid  out  1               output register holds a word
// - out_data   out  DATA_W          registered winning word
// - out_src    out  SEL_W           index of the requester that produced out_data
// - out_ready  in   1               downstream accepts; transfer when out_valid && out_ready
// BEHAVIOUR
// - Reset values:
//   - out_valid=0, out_data=0, out_src=0.
//   - Pointer ptr=0, so requester 0 has top priority after reset.
//   - State UNLOCKED, lock_cnt=0.
//   - req_ready=0 while rst=1.
// - Accept condition: can_acc = !out_valid || out_ready. This gives a full-throughput pipe with no bubble while draining.
// - Arbitration is combinational each cycle:
//   - UNLOCKED: winner is the first i with req_valid[i], scanning ptr, ptr+1, ... mod NUM_REQ.
//   - LOCKED: the only candidate is owner.
//   - req_ready[winner] = can_acc. All other ready bits are 0.
// - Latency: a beat accepted at edge N sets out_valid, out_data and out_src visible after edge N.
// - out_data and out_src are held stable while out_valid && !out_ready.
// - Pointer update: on each accepted beat, ptr <= winner+1 (wraps mod NUM_REQ), including beats taken while LOCKED.
// - FSM UNLOCKED -> LOCKED: on an accepted beat with req_lock[winner]=1 and LOCK_MAX>1. Load owner=winner and lock_cnt=1.
// - FSM LOCKED -> UNLOCKED, on an accepted beat, if either holds:
//   - req_lock[owner]=0, or
//   - lock_cnt+1 == LOCK_MAX (forced release); ptr then moves past owner.
// - FSM LOCKED otherwise: increment lock_cnt on each accepted beat.
// - LOCKED with req_valid[owner]=0: no grant and other requesters wait. The lock is not broken by idle cycles.
// - Simultaneous output drain and new accept in the same cycle: the register is overwritten with the new word and out_valid stays 1.
// - Only the output drain (out_valid=1, no new accept): out_valid goes to 0.
// - Reset mid-operation: any held word is dropped and the lock is cleared. No transfer is reported during rst.
// - A requester must hold req_valid and req_data until accepted. The block does not check this.
// STRUCTURE
// - Package comb_ctrl_pkg holds:
//   - typedef enum logic {UNLOCKED, LOCKED} arb_state_e
//   - function rr_pick(valid, ptr), returning winner index plus found flag
//   - default params NUM_REQ_DEF=4, DATA_W_DEF=32
// - Sub-module rr_priority_encoder: rotates the request vector by ptr, then priority-encodes to an SEL_W index plus found flag. Purely combinational.
// - Top level holds the FSM, ptr, lock_cnt, the word mux and the output register.
// TESTING
// 1. Reset, then req_valid=4'b1111, out_ready=1, data i=32'hA0+i, lock=0.
//    -> out_src sequence 0,1,2,3,0; out_data A0,A1,A2,A3,A0; one beat per cycle.
// 2. req_valid=4'b0101 only.
//    -> grants alternate 0,2,0,2; req_ready[1] and req_ready[3] stay 0.
// 3. out_ready=0 for 3 cycles with requester 1 valid, data 32'hDEAD_BEEF.
//    -> out_valid=1, out_data held, req_ready=0 after the first accept. Drain resumes when out_ready=1.
// 4. Requester 2 asserts lock for 20 beats, others valid, LOCK_MAX=8.
//    -> 8 beats from src 2, then src 3 wins. Requester 2 regains the grant only after its round-robin turn.
// 5. LOCKED owner 1 drops req_valid for 5 cycles while 0 and 3 are valid.
//    -> no grants in that window. Owner's next beat with lock=0 releases, then 3 is granted.
// 6. Assert rst mid-burst with out_valid=1.
//    -> next cycle out_valid=0, state UNLOCKED, first grant goes to requester 0.

Source files
------------

// File: rtl/comb_ctrl_pkg.sv
// Shared types and helpers for the round-robin word-mux arbiter.
package comb_ctrl_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned SEL_W_DEF   = $clog2(NUM_REQ_DEF);

  typedef enum logic {UNLOCKED, LOCKED} arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [SEL_W_DEF-1:0] idx;
  } pick_t;

  // Reference round-robin pick at the default requester count.
  function automatic pick_t rr_pick(input logic [NUM_REQ_DEF-1:0] valid,
                                    input logic [SEL_W_DEF-1:0]   ptr);
    pick_t                p;
    logic [SEL_W_DEF-1:0] c;
    p = '0;
    for (int unsigned i = 0; i < NUM_REQ_DEF; i++) begin
      c = ptr + SEL_W_DEF'(i);
      if (!p.found && valid[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating priority encoder: first set request at or after ptr, wrapping.
module rr_priority_encoder #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  assign dbl = {req, req};
  assign rot = dbl[{1'b0, ptr} +: NUM_REQ];

  always_comb begin
    off = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (rot[i-1]) off = SEL_W'(i - 1);
    end
  end

  assign found = |rot;
  assign idx   = ptr + off;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with burst lock sharing one word mux and a registered output stage.
module rr_mux_arbiter import comb_ctrl_pkg::*; #(
  parameter  int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned LOCK_MAX = 8,
  localparam int unsigned SEL_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [SEL_W-1:0]          grant_sel,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src,
  input  logic                      out_ready
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   owner;
  logic [CNT_W-1:0]   lock_cnt;
  logic [SEL_W-1:0]   pe_idx;
  logic               pe_found;
  logic [SEL_W-1:0]   winner;
  logic               have;
  logic               can_acc;
  logic               accept;
  logic               last_beat;
  logic [DATA_W-1:0]  words [NUM_REQ];
  logic [DATA_W-1:0]  word;

  rr_priority_encoder #(.NUM_REQ(NUM_REQ)) u_pe (
    .req   (req_valid),
    .ptr   (ptr),
    .idx   (pe_idx),
    .found (pe_found)
  );

  assign can_acc   = !out_valid || out_ready;
  assign last_beat = (({1'b0, lock_cnt} + 1'b1) == (CNT_W + 1)'(LOCK_MAX));

  // While locked only the owner may win; idle owner cycles stall everyone.
  always_comb begin
    if (state == LOCKED) begin
      winner = owner;
      have   = req_valid[owner];
    end else begin
      winner = pe_idx;
      have   = pe_found;
    end
    accept    = have && can_acc && !rst;
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  assign grant_sel = winner;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
    word = words[winner];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      state     <= UNLOCKED;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_src   <= winner;
      ptr       <= winner + 1'b1;
      case (state)
        UNLOCKED: begin
          if (req_lock[winner] && (LOCK_MAX > 1)) begin
            state    <= LOCKED;
            owner    <= winner;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!req_lock[owner] || last_beat) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: cycle model of grants plus output queue.
module tb_rr_mux_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned DW       = 32;
  localparam int unsigned LOCK_MAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_lock;
  logic [N-1:0]    req_ready;
  logic [1:0]      grant_sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;

  logic [DW-1:0]   words [N];

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: expected {src, data} pushed on accept, popped on drain.
  logic [33:0] sb [$];

  // Reference model state.
  bit          m_ov;
  int          m_ptr;
  bit          m_locked;
  int          m_owner;
  int          m_cnt;
  logic [63:0] hist;

  rr_mux_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .grant_sel (grant_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = words[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: model predicts at negedge, DUT compared, model advances at posedge.
  task automatic step();
    bit           have, can, acc;
    int           w;
    logic [N-1:0] exp_rdy;
    logic [33:0]  e;
    @(negedge clk);
    can  = !m_ov || out_ready;
    have = 0;
    w    = 0;
    if (m_locked) begin
      w    = m_owner;
      have = req_valid[m_owner];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(m_ptr + k) % N]) begin
          w    = (m_ptr + k) % N;
          have = 1;
        end
      end
    end
    acc     = have && can && !rst;
    exp_rdy = acc ? N'(1 << w) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(0), 64'(1));
      end else begin
        e = sb[0];
        check("out_src", 64'(out_src), 64'(e[33:32]));
        check("out_data", 64'(out_data), 64'(e[31:0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rst && req_valid[i] && req_ready[i]) hist = (hist << 4) | 64'(i + 1);
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_ov     = 0;
      m_ptr    = 0;
      m_locked = 0;
      m_cnt    = 0;
    end else if (acc) begin
      sb.push_back({2'(w), words[w]});
      m_ov  = 1;
      m_ptr = (w + 1) % N;
      if (!m_locked) begin
        if (req_lock[w] && LOCK_MAX > 1) begin
          m_locked = 1;
          m_owner  = w;
          m_cnt    = 1;
        end
      end else if (!req_lock[m_owner] || (m_cnt + 1 == LOCK_MAX)) begin
        m_locked = 0;
      end else begin
        m_cnt++;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_lock  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) words[i] = 32'hA0 + 32'(i);
    m_ov = 0; m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; hist = '0;

    // Reset state, requests already pending
    run(2);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_src", 64'(out_src), 64'(0));

    // 1: all valid, full throughput rotation
    rst  = 1'b0;
    hist = '0;
    run(5);
    check("t1_seq", hist, 64'h12341);

    // 2: only requesters 0 and 2
    req_valid = 4'b0101;
    hist      = '0;
    run(4);
    check("t2_seq", hist, 64'h3131);

    // 3: backpressure holds the word and blocks accepts
    words[1]  = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    hist      = '0;
    run(1);
    out_ready = 1'b0;
    run(3);
    check("t3_hold_valid", 64'(out_valid), 64'(1));
    check("t3_hold_data", 64'(out_data), 64'hDEAD_BEEF);
    check("t3_seq", hist, 64'h2);
    out_ready = 1'b1;
    req_valid = '0;
    run(1);
    check("t3_drained", 64'(out_valid), 64'(0));
    words[1]  = 32'hA1;

    // 4: requester 2 lock capped at LOCK_MAX beats
    req_valid = 4'b1111;
    req_lock  = 4'b0100;
    hist      = '0;
    run(12);
    check("t4_seq", hist, 64'h3333_3333_4123);

    // 6: reset mid-burst with a word held
    check("t6_pre_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    run(1);
    rst      = 1'b0;
    req_lock = '0;
    check("t6_post_valid", 64'(out_valid), 64'(0));

    // 5: locked owner 1 idles, others wait, then releases
    req_valid = 4'b1011;
    req_lock  = 4'b0010;
    hist      = '0;
    run(2);
    req_valid = 4'b1001;
    run(5);
    req_valid = 4'b1011;
    req_lock  = '0;
    run(1);
    req_valid = 4'b1001;
    run(1);
    check("t5_seq", hist, 64'h1224);
    req_valid = '0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
